// File: rtl/ctr_cipher_pkg.sv
// Shared CTR cipher definitions: default widths, keystream mix, stage payload.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package ctr_cipher_pkg;

    localparam int CTR_W   = 32;
    localparam int CTR_ROT = 5;

    // Payload captured in the first pipeline stage.
    typedef struct packed {
        logic [CTR_W-1:0] data;
        logic [CTR_W-1:0] ctr;
        logic [CTR_W-1:0] key;
        logic             last;
    } stage_t;

    // Keystream word for one counter value; the transmit side uses the same mix.
    function automatic logic [CTR_W-1:0] ks_mix(input logic [CTR_W-1:0] ctr,
                                                 input logic [CTR_W-1:0] key,
                                                 input int               rot = CTR_ROT);
        logic [CTR_W-1:0] x;
        x = ctr ^ key;
        return ((x << rot) | (x >> (CTR_W - rot))) ^ (ctr + key);
    endfunction

endpackage

// File: rtl/ctr_keystream_gen.sv
// Per-message counter: seeds from key on new_msg, increments per forwarded word, flags orphans.
// Latency: ctr_o is combinational for the word being accepted; err_orphan_o pulses one cycle later.
// Backpressure: none of its own; state only moves on acc_i, which the top derives from in_ready.
module ctr_keystream_gen
    import ctr_cipher_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_i,
    input  logic         acc_i,
    input  logic         new_msg_i,
    input  logic         last_i,
    output logic [W-1:0] ctr_o,
    output logic         fwd_o,
    output logic         err_orphan_o
);

    logic [W-1:0] ctr_q, ctr_d;
    logic         open_q, open_d;
    logic         err_q, err_d;

    // Counter selection for the accepted word and next counter / message state.
    always_comb begin
        ctr_o  = new_msg_i ? key_i : ctr_q;
        fwd_o  = acc_i & (new_msg_i | open_q);
        ctr_d  = ctr_q;
        open_d = open_q;
        err_d  = 1'b0;
        if (acc_i) begin
            if (new_msg_i | open_q) begin
                // Wraps mod 2^W; a word carrying last closes the message,
                // so a single-word message (new_msg & last) ends closed.
                ctr_d  = ctr_o + W'(1);
                open_d = !last_i;
            end else begin
                // No message open: the word is dropped and the counter left alone.
                err_d = 1'b1;
            end
        end
    end

    // Counter, message-open flag and orphan pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q  <= '0;
            open_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ctr_q  <= ctr_d;
            open_q <= open_d;
            err_q  <= err_d;
        end
    end

    assign err_orphan_o = err_q;

endmodule

// File: rtl/ctr_stream_decryptor.sv
// Receive-side CTR decryptor: regenerates keystream per word and XORs it off the ciphertext.
// Latency: word accepted in cycle N is presented on out_valid in cycle N+2 (sink ready); 1 word/cycle.
// Backpressure: S2 holds while stalled, S1 advances only into a free/draining S2; in_ready follows out_ready combinationally.
module ctr_stream_decryptor
    import ctr_cipher_pkg::*;
#(
    parameter int W   = CTR_W,
    parameter int ROT = CTR_ROT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_new_msg,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         err_orphan
);

    stage_t       s1_q, s1_d;
    logic         s1_vld_q, s1_vld_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         out_vld_q, out_vld_d;

    logic         s2_free;
    logic         s1_adv;
    logic         accept;
    logic         fwd;
    logic [W-1:0] ctr;

    assign s2_free  = !out_vld_q | out_ready;
    assign s1_adv   = s1_vld_q & s2_free;
    assign in_ready = !s1_vld_q | s1_adv;
    assign accept   = in_valid & in_ready;

    ctr_keystream_gen #(
        .W (W)
    ) u_ksgen (
        .clk          (clk),
        .rst          (rst),
        .key_i        (key),
        .acc_i        (accept),
        .new_msg_i    (in_new_msg),
        .last_i       (in_last),
        .ctr_o        (ctr),
        .fwd_o        (fwd),
        .err_orphan_o (err_orphan)
    );

    // Next state for both pipeline stages; stages only load when the slot ahead is free.
    always_comb begin
        s1_d       = s1_q;
        s1_vld_d   = s1_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q;

        // Orphan words are accepted but never enter S1.
        if (fwd) begin
            s1_d.data = in_data;
            s1_d.ctr  = ctr;
            s1_d.key  = key;
            s1_d.last = in_last;
            s1_vld_d  = 1'b1;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        // Key travels with the word so the mix uses the key it was accepted under.
        if (s1_adv) begin
            out_data_d = s1_q.data ^ ks_mix(s1_q.ctr, s1_q.key, ROT);
            out_last_d = s1_q.last;
            out_vld_d  = 1'b1;
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s1_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_vld_q   <= s1_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ctr_stream_decryptor.sv
// Directed bench for ctr_stream_decryptor: hand-computed vectors, scoreboard of expected outputs.
// Inputs driven at the falling edge, outputs sampled 1 time unit later.
// Every comparison is an immediate assertion that counts and reports failures.
module tb_ctr_stream_decryptor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] key;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_new_msg;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        err_orphan;

    always #5 clk = ~clk;

    ctr_stream_decryptor dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_new_msg (in_new_msg),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .err_orphan (err_orphan)
    );

    int          n_tests      = 0;
    int          n_fail       = 0;
    int          cyc_n        = 0;
    int          orphan_cyc   = -10;
    int          acc_cyc      = -1;
    int          last_out_cyc = -1;
    bit          rand_rdy     = 1'b0;
    bit          prev_stall   = 1'b0;
    logic [31:0] prev_data    = '0;
    logic        prev_last    = 1'b0;
    logic [32:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent keystream model (rotate written as a concatenation).
    function automatic logic [31:0] tb_ks(input logic [31:0] c, input logic [31:0] k);
        logic [31:0] x;
        x = c ^ k;
        return {x[26:0], x[31:27]} ^ (c + k);
    endfunction

    // One clock cycle: drive, then check orphan pulse, stall stability and any output transfer.
    task automatic cyc(input logic iv, input logic [31:0] d, input logic nm, input logic lst,
                       output logic acc);
        logic [32:0] e;
        @(negedge clk);
        in_valid   = iv;
        in_data    = d;
        in_new_msg = nm;
        in_last    = lst;
        out_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        cyc_n++;
        chk("err_orphan", 32'(err_orphan), 32'(cyc_n == orphan_cyc + 1));
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
            last_out_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[31:0]);
                chk("out_last", 32'(out_last), 32'(e[32]));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        acc = iv && in_ready;
        if (acc) acc_cyc = cyc_n;
    endtask

    task automatic send(input logic [31:0] d, input logic nm, input logic lst,
                        input logic fwd, input logic [31:0] exp_d);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            cyc(1'b1, d, nm, lst, acc);
            tries++;
        end while (!acc && tries < 50);
        chk("accept", 32'(acc), 32'd1);
        if (acc) begin
            if (fwd) exp_q.push_back({lst, exp_d});
            else     orphan_cyc = cyc_n;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        logic acc;
        int   t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 300) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          a1;
        rst        = 1'b1;
        key        = 32'hADACABAA;
        in_valid   = 1'b0;
        in_data    = '0;
        in_new_msg = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_err", 32'(err_orphan), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Seed word decrypts to zero, two cycles after acceptance.
        send(32'h5B595754, 1'b1, 1'b0, 1'b1, 32'h00000000);
        a1 = acc_cyc;
        idle(2);
        chk("latency", 32'(last_out_cyc - a1), 32'd2);

        // Increment: ctr = key+1, then key+2.
        send(32'h5B595775, 1'b0, 1'b0, 1'b1, 32'h00000000);
        send(32'h12345678, 1'b0, 1'b1, 1'b1, 32'h496D01EE);
        drain();

        // Orphan after last, single-word message, another orphan.
        send(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);
        send(32'h5B595754, 1'b1, 1'b1, 1'b1, 32'h00000000);
        send(32'h00000000, 1'b0, 1'b1, 1'b0, 32'h0);
        drain();

        // Counter wrap: key all-ones gives ctr FFFFFFFF, 0, 1.
        key = 32'hFFFFFFFF;
        send(32'h12345678, 1'b1, 1'b0, 1'b1, 32'hEDCBA986);
        send(32'h12345678, 1'b0, 1'b0, 1'b1, 32'h12345678);
        send(32'h00000000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFDF);
        drain();

        // Eight-word message under random sink backpressure.
        key      = 32'hADACABAA;
        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 32'h01020304 * (i + 1) ^ 32'hA5A50000;
            send(d, i == 0, i == 7, 1'b1, d ^ tb_ks(key + 32'(i), key));
        end
        drain();
        rand_rdy = 1'b0;

        // Reset with two words in flight.
        send(32'h11111111, 1'b1, 1'b0, 1'b1, 32'h0);
        send(32'h22222222, 1'b0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_data", out_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        idle(3);
        // Message state cleared by reset: a continuation word is an orphan.
        send(32'h33333333, 1'b0, 1'b0, 1'b0, 32'h0);
        send(32'h5B595754, 1'b1, 1'b0, 1'b1, 32'h00000000);
        send(32'h5B595775, 1'b0, 1'b1, 1'b1, 32'h00000000);
        drain();

        // Abort: new_msg mid-message reseeds; earlier words drain unaltered.
        send(32'h11111111, 1'b1, 1'b0, 1'b1, 32'h4A484645);
        send(32'h22222222, 1'b0, 1'b0, 1'b1, 32'h797B7557);
        send(32'h5B595754, 1'b1, 1'b0, 1'b1, 32'h00000000);
        send(32'h5B595775, 1'b0, 1'b1, 1'b1, 32'h00000000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
